// File: rtl/coloring_pkg.sv
// Shared constants for the colour scheduler.
// Also consumed by the stand-alone colour checker.
package coloring_pkg;

  localparam int NREQ_C = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] FORBID_A = 2'b00;
  localparam logic [1:0] FORBID_B = 2'b01;

  typedef struct packed {
    logic       v;
    logic [1:0] c;
  } hist_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of one eligible requester.
// Search begins at ptr and wraps around.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic          found
);

  // first eligible index at or after ptr
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && eligible[(int'(ptr) + k) % N]) begin
        winner[(int'(ptr) + k) % N] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/color_scheduler.sv
// Strip colouring scheduler: serves painters
// round-robin and commits only legal colours.
module color_scheduler
  import coloring_pkg::*;
#(
  parameter int NREQ = NREQ_C,
  parameter int LENW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LENW-1:0]   len,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] color_in,
  output logic [NREQ-1:0]   grant,
  output logic              accept,
  output logic              reject,
  output logic              busy,
  output logic              done,
  output logic [LENW-1:0]   count,
  output logic [1:0]        last_color
);

  localparam int PW = $clog2(NREQ);

  state_t          state;
  state_t          state_nx;
  logic [LENW-1:0] len_q;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   widx;
  logic [PW-1:0]   ptr_nx;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] win;
  logic            found;
  logic            sel;
  logic            illegal;
  logic            fin;
  logic            go;
  logic [1:0]      cand;
  hist_t           h0;
  hist_t           h1;

  assign elig = req & ~grant;
  assign sel  = (state == S_RUN) && found;
  assign go   = (state == S_IDLE) && start;

  rr_arbiter #(
    .N  (NREQ),
    .PW (PW)
  ) u_arb (
    .eligible (elig),
    .ptr      (ptr),
    .winner   (win),
    .found    (found)
  );

  // winner index and its proposed colour
  always_comb begin
    widx = '0;
    cand = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) begin
        widx = PW'(i);
        cand = color_in[2*i +: 2];
      end
    end
  end

  // pointer moves just past the winner
  always_comb begin
    if (widx == PW'(NREQ - 1))
      ptr_nx = '0;
    else
      ptr_nx = widx + PW'(1);
  end

  // triple repeat or a forbidden adjacent pair
  always_comb begin
    illegal = 1'b0;
    if (h0.v && h1.v && h0.c == cand && h1.c == cand)
      illegal = 1'b1;
    if (h1.v && h1.c == FORBID_A && cand == FORBID_B)
      illegal = 1'b1;
    if (h1.v && h1.c == FORBID_B && cand == FORBID_A)
      illegal = 1'b1;
  end

  assign fin = sel && !illegal &&
               ((count + LENW'(1)) == len_q);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (start)
          state_nx = (len == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (fin)
          state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
  end

  // grant pulses, commit path and history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant      <= '0;
      accept     <= 1'b0;
      reject     <= 1'b0;
      ptr        <= '0;
      count      <= '0;
      len_q      <= '0;
      last_color <= 2'b00;
      h0         <= '0;
      h1         <= '0;
    end else begin
      grant  <= '0;
      accept <= 1'b0;
      reject <= 1'b0;
      if (go && len != '0) begin
        len_q <= len;
        count <= '0;
        h0.v  <= 1'b0;
        h1.v  <= 1'b0;
      end
      if (sel) begin
        grant <= win;
        ptr   <= ptr_nx;
        if (illegal) begin
          reject <= 1'b1;
        end else begin
          accept     <= 1'b1;
          h0         <= h1;
          h1         <= '{v: 1'b1, c: cand};
          last_color <= cand;
          count      <= count + LENW'(1);
        end
      end
    end
  end

endmodule
